// File: rtl/cfa_tap_window_h.sv
// Streams 5-tap horizontal windows (m2,m1,c,p1,p2) centred on each pixel of a CFA line.
// Edge padding mirrors about the edge pixel; define CFA_EDGE_REPLICATE_EN to replicate it instead.
module cfa_tap_window_h #(
  parameter int pixelBitWidth = 12,
  parameter int LINE_WIDTH    = 640,
  parameter int COL_W         = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [pixelBitWidth-1:0] in_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [pixelBitWidth-1:0] m2,
  output logic [pixelBitWidth-1:0] m1,
  output logic [pixelBitWidth-1:0] c,
  output logic [pixelBitWidth-1:0] p1,
  output logic [pixelBitWidth-1:0] p2,
  output logic [COL_W-1:0]         out_col,
  output logic                     out_eol
);

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(LINE_WIDTH - 1);
  localparam logic [COL_W-1:0] PENULT_COL = COL_W'(LINE_WIDTH - 2);

  typedef logic [pixelBitWidth-1:0] pix_t;
  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH1, S_FLUSH2} state_t;

  state_t           r_state;
  logic [COL_W-1:0] r_col;
  pix_t             r_hist [4];
  pix_t             r_m2, r_m1, r_c, r_p1, r_p2;
  logic             r_out_valid;
  logic [COL_W-1:0] r_out_col;
  logic             r_out_eol;

  logic w_slot_free;
  logic w_in_acc;
  logic w_out_xfer;
  pix_t w_run_m2, w_run_m1, w_fl1_p2, w_fl2_p1, w_fl2_p2;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_in_acc    = in_valid && in_ready;
  assign w_out_xfer  = r_out_valid && out_ready;

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_FILL:  in_ready = 1'b1;
      S_RUN:   in_ready = w_slot_free;
      default: in_ready = 1'b0;
    endcase
  end

  // r_hist[0] holds column k-1 while column k is on the input.
`ifdef CFA_EDGE_REPLICATE_EN
  assign w_run_m2 = (r_col == COL_W'(2)) ? r_hist[1] :
                    (r_col == COL_W'(3)) ? r_hist[2] : r_hist[3];
  assign w_run_m1 = (r_col == COL_W'(2)) ? r_hist[1] : r_hist[2];
  assign w_fl1_p2 = r_hist[0];
  assign w_fl2_p1 = r_hist[0];
  assign w_fl2_p2 = r_hist[0];
`else
  assign w_run_m2 = (r_col == COL_W'(2)) ? in_pixel :
                    (r_col == COL_W'(3)) ? r_hist[1] : r_hist[3];
  assign w_run_m1 = (r_col == COL_W'(2)) ? r_hist[0] : r_hist[2];
  assign w_fl1_p2 = r_hist[1];
  assign w_fl2_p1 = r_hist[1];
  assign w_fl2_p2 = r_hist[2];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)          r_hist[gi] <= '0;
          else if (w_in_acc) r_hist[gi] <= in_pixel;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)          r_hist[gi] <= '0;
          else if (w_in_acc) r_hist[gi] <= r_hist[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FILL;
      r_col       <= '0;
      r_m2        <= '0;
      r_m1        <= '0;
      r_c         <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_eol   <= 1'b0;
    end else begin
      // A drained slot empties unless a new window is loaded below.
      if (w_out_xfer) r_out_valid <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_in_acc) begin
            r_col <= r_col + COL_W'(1);
            if (r_col == COL_W'(1)) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_in_acc) begin
            r_m2        <= w_run_m2;
            r_m1        <= w_run_m1;
            r_c         <= r_hist[1];
            r_p1        <= r_hist[0];
            r_p2        <= in_pixel;
            r_out_valid <= 1'b1;
            r_out_col   <= r_col - COL_W'(2);
            r_out_eol   <= 1'b0;
            if (r_col == LAST_COL) begin
              r_col   <= '0;
              r_state <= S_FLUSH1;
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        S_FLUSH1: begin
          if (w_slot_free) begin
            r_m2        <= r_hist[3];
            r_m1        <= r_hist[2];
            r_c         <= r_hist[1];
            r_p1        <= r_hist[0];
            r_p2        <= w_fl1_p2;
            r_out_valid <= 1'b1;
            r_out_col   <= PENULT_COL;
            r_out_eol   <= 1'b0;
            r_state     <= S_FLUSH2;
          end
        end
        S_FLUSH2: begin
          if (w_slot_free) begin
            r_m2        <= r_hist[2];
            r_m1        <= r_hist[1];
            r_c         <= r_hist[0];
            r_p1        <= w_fl2_p1;
            r_p2        <= w_fl2_p2;
            r_out_valid <= 1'b1;
            r_out_col   <= LAST_COL;
            r_out_eol   <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign m2        = r_m2;
  assign m1        = r_m1;
  assign c         = r_c;
  assign p1        = r_p1;
  assign p2        = r_p2;
  assign out_col   = r_out_col;
  assign out_eol   = r_out_eol;

endmodule

// File: tb/tb_cfa_tap_window_h.sv
// Scoreboard bench for cfa_tap_window_h with an 8-pixel line.
module tb_cfa_tap_window_h;
  localparam int PW = 12;
  localparam int LW = 8;
  localparam int CW = 4;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, out_eol;
  logic [PW-1:0] in_pixel, m2, m1, c, p1, p2;
  logic [CW-1:0] out_col;
  logic [5*PW-1:0] dut_win;

  typedef struct packed {
    logic [5*PW-1:0] win;
    logic [CW-1:0]   col;
    logic            eol;
  } exp_t;

  exp_t            sb_q[$];
  int              checks = 0;
  int              failures = 0;
  logic [PW-1:0]   line_pix [LW];
  int              ready_mode = 0;
  int              hold_seen = 0;
  logic            hold_chk = 1'b0;
  logic [5*PW-1:0] hold_win = '0;

  assign dut_win = {m2, m1, c, p1, p2};

  cfa_tap_window_h #(.pixelBitWidth(PW), .LINE_WIDTH(LW), .COL_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .m2(m2), .m1(m1), .c(c), .p1(p1), .p2(p2),
    .out_col(out_col), .out_eol(out_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed windows for a line whose column x holds base+x+1.
  function automatic exp_t hand_exp(int x, int base);
    int   v [5];
    exp_t e;
`ifdef CFA_EDGE_REPLICATE_EN
    case (x)
      0:       v = '{1, 1, 1, 2, 3};
      1:       v = '{1, 1, 2, 3, 4};
      6:       v = '{5, 6, 7, 8, 8};
      7:       v = '{6, 7, 8, 8, 8};
      default: v = '{x - 1, x, x + 1, x + 2, x + 3};
    endcase
`else
    case (x)
      0:       v = '{3, 2, 1, 2, 3};
      1:       v = '{2, 1, 2, 3, 4};
      6:       v = '{5, 6, 7, 8, 7};
      7:       v = '{6, 7, 8, 7, 6};
      default: v = '{x - 1, x, x + 1, x + 2, x + 3};
    endcase
`endif
    for (int t = 0; t < 5; t++) e.win[(4 - t) * PW +: PW] = PW'(base + v[t]);
    e.col = CW'(x);
    e.eol = (x == LW - 1);
    return e;
  endfunction

  // Reference window for arbitrary line contents in line_pix.
  function automatic exp_t model_exp(int x);
    exp_t e;
    int   j;
    for (int t = 0; t < 5; t++) begin
      j = x + t - 2;
`ifdef CFA_EDGE_REPLICATE_EN
      if (j < 0) j = 0;
      if (j > LW - 1) j = LW - 1;
`else
      if (j < 0) j = -j;
      if (j > LW - 1) j = 2 * (LW - 1) - j;
`endif
      e.win[(4 - t) * PW +: PW] = line_pix[j];
    end
    e.col = CW'(x);
    e.eol = (x == LW - 1);
    return e;
  endfunction

  task automatic chk(input string name, input longint got, input longint req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic set_line(input int base);
    for (int i = 0; i < LW; i++) line_pix[i] = PW'(base + i + 1);
  endtask

  task automatic push_hand(input int base);
    for (int x = 0; x < LW; x++) sb_q.push_back(hand_exp(x, base));
  endtask

  // Called at posedge+1; returns at posedge+1 after the last accept.
  task automatic send_pixels(input int n, input bit gap_on, output int stalls);
    bit acc;
    int waited;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      if (gap_on && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_pixel = line_pix[i];
      acc      = 1'b0;
      waited   = 0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (!acc) begin
          stalls++;
          waited++;
        end
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout col=%0d got in_ready=0 required 1", i);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  // out_ready driver: 0 always ready, 1 stalled, 2 random, 3 stall 5 cycles at centre 3.
  initial begin
    int hold_cnt = 0;
    bit hold_done = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: begin
          out_ready = 1'b1;
          hold_done = 1'b0;
        end
        1: out_ready = 1'b0;
        2: out_ready = ($urandom_range(0, 1) == 1);
        default: begin
          if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
          end else if (!hold_done && out_valid && out_col == CW'(3)) begin
            out_ready = 1'b0;
            hold_cnt  = 4;
            hold_done = 1'b1;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: every output transfer is checked against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (hold_chk && !out_ready) begin
          hold_seen++;
          checks++;
          if (dut_win !== hold_win || out_col !== CW'(3) || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold got win=%h col=%0d in_ready=%0b required win=%h col=3 in_ready=0",
                     dut_win, out_col, in_ready, hold_win);
          end
        end
        if (out_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_window got col=%0d required no window", out_col);
          end else begin
            e = sb_q.pop_front();
            if (dut_win !== e.win || out_col !== e.col || out_eol !== e.eol) begin
              failures++;
              $display("FAIL window got win=%h col=%0d eol=%0b required win=%h col=%0d eol=%0b",
                       dut_win, out_col, out_eol, e.win, e.col, e.eol);
            end else begin
              $display("window col=%0d win=%h eol=%0b ok", out_col, dut_win, out_eol);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    #1 rst = 1'b0;
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_taps", dut_win, 0);
    chk("reset_out_col", out_col, 0);
    chk("reset_out_eol", out_eol, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Continuous line 1..8, then back-to-back line 101..108.
    ready_mode = 0;
    set_line(0);
    push_hand(0);
    send_pixels(LW, 1'b0, st);
    chk("line1_stalls", st, 0);
    set_line(100);
    push_hand(100);
    send_pixels(LW, 1'b0, st);
    chk("flush_stalls", st, 2);

    // Downstream stall of 5 cycles while centre 3 is presented.
    hold_win   = hand_exp(3, 20).win;
    hold_chk   = 1'b1;
    ready_mode = 3;
    set_line(20);
    push_hand(20);
    send_pixels(LW, 1'b0, st);
    chk("hold_stalls", st, 7);
    chk("hold_cycles", hold_seen, 5);
    hold_chk   = 1'b0;
    ready_mode = 0;

    // Asynchronous reset after 5 pixels with centre 2 still held.
    set_line(40);
    sb_q.push_back(hand_exp(0, 40));
    sb_q.push_back(hand_exp(1, 40));
    send_pixels(5, 1'b0, st);
    ready_mode = 1;
    #3;
    chk("pre_reset_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_taps", dut_win, 0);
    chk("async_reset_col", out_col, 0);
    chk("async_reset_eol", out_eol, 0);
    chk("sb_empty_at_reset", sb_q.size(), 0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    ready_mode = 0;
    set_line(60);
    push_hand(60);
    send_pixels(LW, 1'b0, st);
    chk("post_reset_stalls", st, 0);

    // 100 random lines with input gaps and random downstream readiness.
    ready_mode = 2;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < LW; i++) line_pix[i] = PW'($urandom_range(0, 4095));
      for (int x = 0; x < LW; x++) sb_q.push_back(model_exp(x));
      send_pixels(LW, 1'b1, st);
    end
    ready_mode = 0;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
